// File: rtl/reorder_buffer_nway.sv
// N-way reorder buffer: in-order dispatch, out-of-order CDB completion, in-order retire with flush on mispredict.
// Optional performance counters are compiled in when ROB_PERF_CNT_EN is defined.
module reorder_buffer_nway #(
  parameter int unsigned ROB_DEPTH    = 16,
  parameter int unsigned DISP_WIDTH   = 2,
  parameter int unsigned CDB_WIDTH    = 2,
  parameter int unsigned RET_WIDTH    = 2,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  localparam int unsigned TAG_W       = $clog2(ROB_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DISP_WIDTH-1:0]            disp_valid,
  input  logic [DISP_WIDTH-1:0]            disp_has_dest,
  input  logic [DISP_WIDTH*REG_ADDR_LEN-1:0] disp_reg,
  output logic                             disp_ready,
  output logic [DISP_WIDTH*TAG_W-1:0]      disp_tag,
  input  logic [CDB_WIDTH-1:0]             cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]       cdb_tag,
  input  logic [CDB_WIDTH*XLEN-1:0]        cdb_data,
  input  logic [CDB_WIDTH*XLEN-1:0]        cdb_target_pc,
  input  logic [CDB_WIDTH-1:0]             cdb_mispredict,
  output logic [RET_WIDTH-1:0]             ret_valid,
  output logic [RET_WIDTH-1:0]             ret_wen,
  output logic [RET_WIDTH*REG_ADDR_LEN-1:0] ret_reg,
  output logic [RET_WIDTH*XLEN-1:0]        ret_data,
  output logic                             flush,
  output logic [XLEN-1:0]                  flush_pc,
  output logic [TAG_W:0]                   free_slots
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [63:0]                      perf_retired,
  output logic [31:0]                      perf_flushes
`endif
);

  logic [ROB_DEPTH-1:0]    valid_q;
  logic [ROB_DEPTH-1:0]    ready_q;
  logic [ROB_DEPTH-1:0]    has_dest_q;
  logic [ROB_DEPTH-1:0]    misp_q;
  logic [REG_ADDR_LEN-1:0] reg_q  [ROB_DEPTH];
  logic [XLEN-1:0]         data_q [ROB_DEPTH];
  logic [XLEN-1:0]         tpc_q  [ROB_DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [TAG_W:0]   disp_cnt;
  logic [TAG_W:0]   ret_cnt;
  logic [TAG_W-1:0] ret_idx;
  logic             ret_stop;

  assign free_slots = (TAG_W+1)'(ROB_DEPTH) - count_q;

  // Lane tags are packed: a lane's tag skips over invalid lanes below it.
  always_comb begin
    disp_cnt = '0;
    disp_tag = '0;
    for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
      disp_tag[i*TAG_W +: TAG_W] = tail_q + disp_cnt[TAG_W-1:0];
      disp_cnt = disp_cnt + (TAG_W+1)'(disp_valid[i]);
    end
    disp_ready = (disp_cnt <= free_slots);
  end

  always_comb begin
    ret_valid = '0;
    ret_wen   = '0;
    ret_reg   = '0;
    ret_data  = '0;
    flush     = 1'b0;
    flush_pc  = '0;
    ret_cnt   = '0;
    ret_stop  = 1'b0;
    ret_idx   = '0;
    for (int unsigned k = 0; k < RET_WIDTH; k++) begin
      ret_idx = head_q + TAG_W'(k);
      if (!ret_stop && valid_q[ret_idx] && ready_q[ret_idx]) begin
        ret_valid[k]                          = 1'b1;
        ret_wen[k]                            = has_dest_q[ret_idx];
        ret_reg[k*REG_ADDR_LEN +: REG_ADDR_LEN] = reg_q[ret_idx];
        ret_data[k*XLEN +: XLEN]              = data_q[ret_idx];
        ret_cnt                               = ret_cnt + 1'b1;
        if (misp_q[ret_idx]) begin
          flush    = 1'b1;
          flush_pc = tpc_q[ret_idx];
          ret_stop = 1'b1;
        end
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q + ret_cnt[TAG_W-1:0];
    tail_d  = tail_q;
    count_d = count_q - ret_cnt;
    if (disp_ready) begin
      tail_d  = tail_q + disp_cnt[TAG_W-1:0];
      count_d = count_d + disp_cnt;
    end
  end

  // Update order matters: completion, then retire clear, then allocation (later NBA wins).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q    <= '0;
      ready_q    <= '0;
      has_dest_q <= '0;
      misp_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned c = 0; c < CDB_WIDTH; c++) begin
        if (cdb_valid[c] && valid_q[cdb_tag[c*TAG_W +: TAG_W]]) begin
          ready_q[cdb_tag[c*TAG_W +: TAG_W]] <= 1'b1;
          misp_q[cdb_tag[c*TAG_W +: TAG_W]]  <= cdb_mispredict[c];
          data_q[cdb_tag[c*TAG_W +: TAG_W]]  <= cdb_data[c*XLEN +: XLEN];
          tpc_q[cdb_tag[c*TAG_W +: TAG_W]]   <= cdb_target_pc[c*XLEN +: XLEN];
        end
      end
      for (int unsigned k = 0; k < RET_WIDTH; k++) begin
        if (ret_valid[k]) begin
          valid_q[head_q + TAG_W'(k)] <= 1'b0;
          ready_q[head_q + TAG_W'(k)] <= 1'b0;
        end
      end
      if (disp_ready) begin
        for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
          if (disp_valid[i]) begin
            valid_q[disp_tag[i*TAG_W +: TAG_W]]    <= 1'b1;
            ready_q[disp_tag[i*TAG_W +: TAG_W]]    <= 1'b0;
            misp_q[disp_tag[i*TAG_W +: TAG_W]]     <= 1'b0;
            has_dest_q[disp_tag[i*TAG_W +: TAG_W]] <= disp_has_dest[i];
            reg_q[disp_tag[i*TAG_W +: TAG_W]]      <= disp_reg[i*REG_ADDR_LEN +: REG_ADDR_LEN];
          end
        end
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      perf_retired <= perf_retired + 64'(ret_cnt);
      if (flush) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer_nway.sv
// Scoreboard bench for reorder_buffer_nway: a queue-based program-order model predicts retirements,
// a separate monitor compares each retiring lane against the expected stream.
module tb_reorder_buffer_nway;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW = 2, CW = 2, RW = 2, XL = 32, RL = 5, TW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0]    disp_valid, disp_has_dest;
  logic [DW*RL-1:0] disp_reg;
  logic             disp_ready;
  logic [DW*TW-1:0] disp_tag;
  logic [CW-1:0]    cdb_valid, cdb_mispredict;
  logic [CW*TW-1:0] cdb_tag;
  logic [CW*XL-1:0] cdb_data, cdb_target_pc;
  logic [RW-1:0]    ret_valid, ret_wen;
  logic [RW*RL-1:0] ret_reg;
  logic [RW*XL-1:0] ret_data;
  logic             flush;
  logic [XL-1:0]    flush_pc;
  logic [TW:0]      free_slots;
`ifdef ROB_PERF_CNT_EN
  logic [63:0]      perf_retired;
  logic [31:0]      perf_flushes;
`endif

  reorder_buffer_nway #(
    .ROB_DEPTH(DEPTH), .DISP_WIDTH(DW), .CDB_WIDTH(CW), .RET_WIDTH(RW),
    .XLEN(XL), .REG_ADDR_LEN(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_has_dest(disp_has_dest), .disp_reg(disp_reg),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_target_pc(cdb_target_pc), .cdb_mispredict(cdb_mispredict),
    .ret_valid(ret_valid), .ret_wen(ret_wen), .ret_reg(ret_reg), .ret_data(ret_data),
    .flush(flush), .flush_pc(flush_pc), .free_slots(free_slots)
`ifdef ROB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int        tag;
    bit        has_dest;
    bit [4:0]  rg;
    bit        done;
    bit [31:0] data;
    bit [31:0] tpc;
    bit        misp;
  } ent_t;

  typedef struct {
    bit [4:0]  rg;
    bit        wen;
    bit [31:0] data;
    bit        misp;
    bit [31:0] tpc;
  } ret_t;

  ent_t rob[$];
  ret_t exp_q[$];
  int   alloc_seq;
  int   cur_rn;
  bit   cur_flush;
  bit   cur_dready;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  longint exp_retired;
  int   exp_flushes;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Retirement for the current cycle: in-order prefix of completed entries, cut after a mispredict.
  task automatic model_retire();
    ret_t r;
    cur_rn = 0;
    cur_flush = 1'b0;
    for (int k = 0; k < RW && k < rob.size(); k++) begin
      if (!rob[k].done) break;
      r.rg = rob[k].rg; r.wen = rob[k].has_dest; r.data = rob[k].data;
      r.misp = rob[k].misp; r.tpc = rob[k].tpc;
      exp_q.push_back(r);
      cur_rn++;
      if (rob[k].misp) begin
        cur_flush = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_edge();
    ent_t e;
    exp_retired += longint'(cur_rn);
    if (cur_flush) begin
      exp_flushes++;
      rob.delete();
      alloc_seq = 0;
    end else begin
      repeat (cur_rn) void'(rob.pop_front());
      for (int c = 0; c < CW; c++)
        if (cdb_valid[c])
          foreach (rob[j])
            if (rob[j].tag == int'(cdb_tag[c*TW +: TW])) begin
              rob[j].done = 1'b1;
              rob[j].data = cdb_data[c*XL +: XL];
              rob[j].tpc  = cdb_target_pc[c*XL +: XL];
              rob[j].misp = cdb_mispredict[c];
            end
      if (cur_dready)
        for (int i = 0; i < DW; i++)
          if (disp_valid[i]) begin
            e.tag = alloc_seq % DEPTH; e.has_dest = disp_has_dest[i];
            e.rg = disp_reg[i*RL +: RL]; e.done = 1'b0; e.data = 0; e.tpc = 0; e.misp = 1'b0;
            rob.push_back(e);
            alloc_seq++;
          end
    end
  endtask

  // Entered at posedge+1; drives one cycle of stimulus and leaves at the next posedge+1.
  task automatic cycle(input logic [DW-1:0] dv, input logic [DW-1:0] hd, input logic [DW*RL-1:0] rg,
                       input logic [CW-1:0] cv, input logic [CW-1:0] cm, input logic [CW*TW-1:0] ct,
                       input logic [CW*XL-1:0] cd, input logic [CW*XL-1:0] cp);
    int pre;
    model_retire();
    disp_valid = dv; disp_has_dest = hd; disp_reg = rg;
    cdb_valid = cv; cdb_mispredict = cm; cdb_tag = ct; cdb_data = cd; cdb_target_pc = cp;
    cur_dready = ($countones(dv) <= DEPTH - rob.size());
    #3;
    chk("disp_ready", 64'(disp_ready), 64'(cur_dready));
    chk("free_slots", 64'(free_slots), 64'(DEPTH - rob.size()));
    pre = 0;
    for (int i = 0; i < DW; i++)
      if (dv[i]) begin
        chk("disp_tag", 64'(disp_tag[i*TW +: TW]), 64'((alloc_seq + pre) % DEPTH));
        pre++;
      end
    @(posedge clk); #1;
    model_edge();
  endtask

  task automatic idle();
    cycle('0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic disp2(input int n);
    logic [DW-1:0] dv;
    dv = (n >= 2) ? 2'b11 : 2'b01;
    cycle(dv, 2'b11, DW*RL'($urandom), '0, '0, '0, '0, '0);
  endtask

  task automatic comp2(input int t0, input int t1, input bit m0);
    logic [CW*TW-1:0] ct;
    logic [CW*XL-1:0] cd;
    ct = {TW'(t1), TW'(t0)};
    cd = {32'h100 + 32'(t1), 32'h100 + 32'(t0)};
    cycle('0, '0, '0, 2'b11, {1'b0, m0}, ct, cd, {32'h0, 32'h400});
  endtask

  task automatic do_reset();
    model_retire();
    reset = 1'b1;
    disp_valid = DW'($urandom); cdb_valid = CW'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    rob.delete(); alloc_seq = 0; exp_retired = 0; exp_flushes = 0;
    disp_valid = '0; cdb_valid = '0;
  endtask

  task automatic rand_cycle(input int pc, input int pm);
    logic [CW-1:0]    cv, cm;
    logic [CW*TW-1:0] ct;
    int idx;
    cv = '0; cm = '0; ct = '0;
    for (int c = 0; c < CW; c++) begin
      if (rob.size() > 0 && $urandom_range(99) < pc) begin
        cv[c] = 1'b1;
        idx = $urandom_range(rob.size() - 1);
        ct[c*TW +: TW] = TW'(rob[idx].tag);
      end else if ($urandom_range(19) == 0) begin
        cv[c] = 1'b1;
        ct[c*TW +: TW] = TW'($urandom_range(DEPTH - 1));
      end
      cm[c] = ($urandom_range(99) < pm);
    end
    if ($urandom_range(9) == 0) ct[TW +: TW] = ct[0 +: TW];
    cycle(DW'($urandom), DW'($urandom), DW*RL'($urandom), cv, cm, ct,
          {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Monitor: pops one expected record per retiring lane and checks flush against the popped stream.
  initial begin
    ret_t r;
    bit ef;
    logic [31:0] ep;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ef = 1'b0;
        ep = '0;
        for (int k = 0; k < RW; k++)
          if (ret_valid[k] === 1'b1) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL ret_extra: lane %0d retired with nothing expected at %0t", k, $time);
            end else begin
              r = exp_q.pop_front();
              chk("ret_reg",  64'(ret_reg[k*RL +: RL]),  64'(r.rg));
              chk("ret_wen",  64'(ret_wen[k]),           64'(r.wen));
              chk("ret_data", 64'(ret_data[k*XL +: XL]), 64'(r.data));
              if (r.misp) begin
                ef = 1'b1;
                ep = r.tpc;
              end
            end
          end
        chk("flush", 64'(flush), 64'(ef));
        if (ef) chk("flush_pc", 64'(flush_pc), 64'(ep));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    disp_valid = '0; disp_has_dest = '0; disp_reg = '0;
    cdb_valid = '0; cdb_mispredict = '0; cdb_tag = '0; cdb_data = '0; cdb_target_pc = '0;
    rob.delete(); alloc_seq = 0; exp_retired = 0; exp_flushes = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_free_slots", 64'(free_slots), 64'(DEPTH));
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_ret_valid",  64'(ret_valid), 64'd0);
    chk("rst_flush",      64'(flush), 64'd0);
    chk("rst_flush_pc",   64'(flush_pc), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Two-lane dispatch, out-of-order completion, paired retire.
    cycle(2'b11, 2'b11, {5'd4, 5'd3}, '0, '0, '0, '0, '0);
    cycle('0, '0, '0, 2'b01, '0, {4'd0, 4'd1}, {32'h0, 32'hBB}, '0);
    cycle('0, '0, '0, 2'b01, '0, {4'd0, 4'd0}, {32'h0, 32'hAA}, '0);
    idle(); idle();

    // Fill to full, then a refused single-lane dispatch.
    repeat (8) disp2(2);
    disp2(1);
    // Mispredict at head with younger entries ready.
    comp2(rob[1].tag, rob[2].tag, 1'b0);
    comp2(rob[0].tag, rob[0].tag, 1'b1);
    idle(); idle();

    // Duplicate completion tags in one cycle.
    disp2(1);
    cycle('0, '0, '0, 2'b11, '0, {TW'(rob[0].tag), TW'(rob[0].tag)}, {32'h2, 32'h1}, '0);
    idle(); idle();

    // Walk head to 15, then retire a group straddling 15 -> 0.
    repeat (7) disp2(2);
    for (int j = 0; j < 7; j++) comp2(rob[0].tag, rob[1].tag, 1'b0);
    idle(); idle();
    disp2(2);
    comp2(rob[0].tag, rob[1].tag, 1'b0);
    idle(); idle();

    // Randomized phases with varying completion and mispredict pressure.
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < 400; n++)
        rand_cycle((p % 3 == 0) ? 10 : (p % 3 == 1) ? 50 : 90, (p < 3) ? 2 : 8);
      if (p == 3) do_reset();
    end

    // Drain all outstanding entries.
    for (int n = 0; n < 200 && rob.size() > 0; n++) begin
      if (!rob[0].done) comp2(rob[0].tag, (rob.size() > 1) ? rob[1].tag : rob[0].tag, 1'b0);
      else idle();
    end
    idle(); idle();
    chk("drain_free_slots", 64'(free_slots), 64'(DEPTH - rob.size()));
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef ROB_PERF_CNT_EN
    chk("perf_retired", perf_retired, 64'(exp_retired));
    chk("perf_flushes", 64'(perf_flushes), 64'(exp_flushes));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
